// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU output UART: serializer state encoding,
// frame-size constants and the default bit period (50 MHz / 115200 baud).
// Build macro CPU_OUTPUT_UART_PARITY_EN adds an even-parity bit (11-bit frame).
package cpu_io_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DATA_BITS            = 8;

`ifdef CPU_OUTPUT_UART_PARITY_EN
  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;
`else
  // start + 8 data + stop
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;
`endif

endpackage

// File: rtl/uart_tx_serializer.sv
// Purpose: UART frame serializer (start, 8 data LSB first, [even parity], stop).
// Latency: byte loaded at edge n drives the start bit on tx_o from edge n+1.
// Backpressure: ready_o high in IDLE and in the last stop-bit cycle; load_i is
//   only honoured while ready_o is high, so back-to-back frames have no gap.
// Ports: clk, rst_n (sync, active-low), load_i/data_i/ready_o handshake,
//   tx_o serial line (idle high), busy_o high for the whole frame on tx_o.
// Build macro CPU_OUTPUT_UART_PARITY_EN adds the PARITY state.
module uart_tx_serializer
  import cpu_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int              BIT_W         = $clog2(FRAME_BITS);
  localparam logic [15:0]     BAUD_LAST     = 16'(CLKS_PER_BIT - 1);
  // bit_q tracks the position within the frame: 0 = start, 1..8 = data.
  localparam logic [BIT_W-1:0] LAST_DATA_POS = BIT_W'(DATA_BITS);
  localparam logic [BIT_W-1:0] BIT_ONE       = BIT_W'(1);

  tx_state_e            state_q, state_d;
  logic [15:0]          baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 tx_q, tx_d;
  logic                 busy_q;
  logic                 bit_done;
`ifdef CPU_OUTPUT_UART_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign bit_done = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 16'd1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = 1'b1;
    ready_o = 1'b0;
`ifdef CPU_OUTPUT_UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_d  = '0;
        ready_o = 1'b1;
        if (load_i) begin
          state_d = ST_START;
          bit_d   = '0;
          shreg_d = data_i;
`ifdef CPU_OUTPUT_UART_PARITY_EN
          par_d   = ^data_i;
`endif
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = bit_q + BIT_ONE;
        end
      end
      ST_DATA: begin
        tx_d = shreg_q[0];
        if (bit_done) begin
          baud_d  = '0;
          bit_d   = bit_q + BIT_ONE;
          shreg_d = shreg_q >> 1;
          if (bit_q == LAST_DATA_POS) begin
`ifdef CPU_OUTPUT_UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef CPU_OUTPUT_UART_PARITY_EN
      ST_PARITY: begin
        tx_d = par_q;
        if (bit_done) begin
          state_d = ST_STOP;
          baud_d  = '0;
          bit_d   = bit_q + BIT_ONE;
        end
      end
`endif
      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          // Last stop-bit cycle: take the next byte straight into START.
          baud_d  = '0;
          bit_d   = '0;
          ready_o = 1'b1;
          if (load_i) begin
            state_d = ST_START;
            shreg_d = data_i;
`ifdef CPU_OUTPUT_UART_PARITY_EN
            par_d   = ^data_i;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // tx and busy are registered, so both lag the state by one cycle and stay
  // aligned with each other.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef CPU_OUTPUT_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= (state_q != ST_IDLE);
`ifdef CPU_OUTPUT_UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/cpu_output_uart.sv
// Purpose: CPU output port to UART bridge: byte FIFO, sticky overflow, serializer.
// Latency: strobe at edge k into an empty idle block drives tx low from edge k+2.
// Backpressure: none toward the CPU; a strobe into a full FIFO with no pop on
//   the same edge is dropped and sets the sticky overflow flag.
// Ports: clk, rst_n (sync, active-low), data_out/data_out_en strobe,
//   overflow_clr; outputs tx (idle high), fifo_level, overflow, busy.
// Build macro CPU_OUTPUT_UART_PARITY_EN selects the 11-bit even-parity frame.
module cpu_output_uart
  import cpu_io_pkg::*;
#(
  parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               data_out,
  input  logic                     data_out_en,
  input  logic                     overflow_clr,
  output logic                     tx,
  output logic [FIFO_DEPTH_LOG2:0] fifo_level,
  output logic                     overflow,
  output logic                     busy
);

  localparam int                         DEPTH    = 1 << FIFO_DEPTH_LOG2;
  localparam int                         LVL_W    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0]           LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]           LVL_ONE  = LVL_W'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);

  logic [7:0]                 mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]           level_q, level_d;
  logic                       ovf_q, ovf_d;
  logic                       empty, full, push, pop, drop, ser_rdy;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_FULL);
  assign pop   = ser_rdy & ~empty;
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push  = data_out_en & (~full | pop);
  assign drop  = data_out_en & full & ~pop;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    // Set wins over a coincident clear.
    ovf_d = drop | (ovf_q & ~overflow_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= data_out;
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (pop),
    .data_i (mem_q[rd_ptr_q]),
    .ready_o(ser_rdy),
    .tx_o   (tx),
    .busy_o (busy)
  );

  assign fifo_level = level_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_cpu_output_uart.sv
// Bench for cpu_output_uart with CLKS_PER_BIT=4, FIFO_DEPTH_LOG2=4.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
// tx/busy samples are logged per cycle while recording is on and decoded afterwards.
module tb_cpu_output_uart;

  localparam int CPB  = 4;
  localparam int LOG2 = 4;
`ifdef CPU_OUTPUT_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME_CYC = FB * CPB;
  localparam int REC_MAX   = 1024;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_out;
  logic       data_out_en;
  logic       overflow_clr;
  logic       tx;
  logic [4:0] fifo_level;
  logic       overflow;
  logic       busy;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic rec_on   = 1'b0;
  int   rec_len  = 0;
  logic rec_tx   [REC_MAX];
  logic rec_busy [REC_MAX];

  cpu_output_uart #(
    .CLKS_PER_BIT   (CPB),
    .FIFO_DEPTH_LOG2(LOG2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_out    (data_out),
    .data_out_en (data_out_en),
    .overflow_clr(overflow_clr),
    .tx          (tx),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rec_on && rec_len < REC_MAX) begin
      rec_tx[rec_len]   = tx;
      rec_busy[rec_len] = busy;
      rec_len++;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; data_out = 8'h00; data_out_en = 1'b0; overflow_clr = 1'b0;
    rec_on = 1'b0; rec_len = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic start_rec();
    rec_len = 0;
    rec_on  = 1'b1;
  endtask

  // Run until the block has been idle and empty for 3 consecutive samples.
  task automatic drain(input int limit, output bit timed_out);
    int idle = 0;
    int n    = 0;
    timed_out = 1'b0;
    while (idle < 3) begin
      if (n >= limit) begin
        timed_out = 1'b1;
        break;
      end
      tick();
      n++;
      if (busy === 1'b0 && fifo_level === 5'd0) idle++;
      else idle = 0;
    end
    rec_on = 1'b0;
  endtask

  function automatic int first_busy();
    for (int i = 0; i < rec_len; i++) if (rec_busy[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int busy_count();
    int c = 0;
    for (int i = 0; i < rec_len; i++) if (rec_busy[i] === 1'b1) c++;
    return c;
  endfunction

  // Decode one recorded frame starting at sample st; ok=0 on any framing error.
  task automatic decode_frame(input int st, output logic [7:0] d, output bit ok);
    ok = 1'b1;
    d  = 8'h00;
    if (st < 0 || st + FRAME_CYC > rec_len) begin
      ok = 1'b0;
      return;
    end
    for (int b = 0; b < FB; b++) begin
      logic v;
      v = rec_tx[st + b * CPB];
      for (int s = 0; s < CPB; s++) begin
        if (rec_tx[st + b * CPB + s] !== v || rec_busy[st + b * CPB + s] !== 1'b1) ok = 1'b0;
      end
      if (b == 0 && v !== 1'b0) ok = 1'b0;
      if (b >= 1 && b <= 8) d[b-1] = v;
`ifdef CPU_OUTPUT_UART_PARITY_EN
      if (b == 9 && v !== ^d) ok = 1'b0;
`endif
      if (b == FB - 1 && v !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data_out = 8'hA5; data_out_en = 1'b1; overflow_clr = 1'b0;
    tick(); tick();
    n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx); else n_pass++;
    n_checks++; if (fifo_level !== 5'd0) $display("FAIL reset_level: got %0d expected 0", fifo_level); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    rst_n = 1'b1; data_out_en = 1'b0;
    tick(); tick();
    n_checks++; if (fifo_level !== 5'd0) $display("FAIL reset_strobe_ignored: level got %0d expected 0", fifo_level); else n_pass++;
    n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx_idle: got %b expected 1", tx); else n_pass++;
  endtask

  task automatic test_single();
    bit to; int s; logic [7:0] d; bit ok;
    apply_reset();
    start_rec();
    data_out = 8'h41; data_out_en = 1'b1;
    tick();                       // edge k
    data_out_en = 1'b0;
    n_checks++; if (fifo_level !== 5'd1) $display("FAIL single_level_k: got %0d expected 1", fifo_level); else n_pass++;
    tick();                       // edge k+1
    n_checks++; if (tx !== 1'b1) $display("FAIL single_tx_k1: got %b expected 1", tx); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_k1: got %b expected 0", busy); else n_pass++;
    tick();                       // edge k+2
    n_checks++; if (tx !== 1'b0) $display("FAIL single_tx_k2: got %b expected 0", tx); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_k2: got %b expected 1", busy); else n_pass++;
    drain(300, to);
    n_checks++; if (to) $display("FAIL single_drain: got timeout expected idle"); else n_pass++;
    s = first_busy();
    n_checks++; if (s !== 2) $display("FAIL single_start_idx: got %0d expected 2", s); else n_pass++;
    n_checks++; if (busy_count() !== 40) $display("FAIL single_busy_len: got %0d expected 40", busy_count()); else n_pass++;
    decode_frame(s, d, ok);
    n_checks++; if (!ok || d !== 8'h41) $display("FAIL single_data: got %h framing_ok=%0d expected 41", d, ok); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL single_overflow: got %b expected 0", overflow); else n_pass++;
  endtask

  task automatic test_parity();
    bit to; int s; logic [7:0] d; bit ok;
    apply_reset();
    start_rec();
    data_out = 8'h07; data_out_en = 1'b1;
    tick();
    data_out_en = 1'b0;
    drain(300, to);
    n_checks++; if (to) $display("FAIL parity_drain: got timeout expected idle"); else n_pass++;
    s = first_busy();
    decode_frame(s, d, ok);
    n_checks++; if (!ok || d !== 8'h07) $display("FAIL parity_data: got %h framing_ok=%0d expected 07", d, ok); else n_pass++;
`ifdef CPU_OUTPUT_UART_PARITY_EN
    n_checks++; if (busy_count() !== 44) $display("FAIL parity_frame_len: got %0d expected 44", busy_count()); else n_pass++;
    n_checks++; if (rec_tx[s + 36] !== 1'b1 || rec_tx[s + 39] !== 1'b1) $display("FAIL parity_bit: got %b expected 1", rec_tx[s + 36]); else n_pass++;
`else
    n_checks++; if (busy_count() !== 40) $display("FAIL parity_frame_len: got %0d expected 40", busy_count()); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    bit to; int s; int peak; logic [7:0] d; bit ok;
    apply_reset();
    start_rec();
    peak = 0;
    for (int i = 0; i < 20; i++) begin
      data_out = 8'(i); data_out_en = 1'b1;
      tick();
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    data_out_en = 1'b0;
    drain(2000, to);
    n_checks++; if (to) $display("FAIL b2b_drain: got timeout expected idle"); else n_pass++;
    n_checks++; if (peak !== 16) $display("FAIL b2b_peak_level: got %0d expected 16", peak); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL b2b_overflow: got %b expected 1", overflow); else n_pass++;
    n_checks++; if (busy_count() !== 17 * FRAME_CYC) $display("FAIL b2b_busy_len: got %0d expected %0d", busy_count(), 17 * FRAME_CYC); else n_pass++;
    s = first_busy();
    for (int f = 0; f < 17; f++) begin
      decode_frame(s + f * FRAME_CYC, d, ok);
      n_checks++; if (!ok || d !== 8'(f)) $display("FAIL b2b_frame%0d: got %h framing_ok=%0d expected %h", f, d, ok, 8'(f)); else n_pass++;
    end
  endtask

  task automatic test_full_pop_overflow();
    bit to; int s; logic [7:0] d; bit ok;
    apply_reset();
    start_rec();
    for (int i = 0; i < 17; i++) begin
      data_out = 8'(i); data_out_en = 1'b1;
      tick();                     // edges k .. k+16
    end
    data_out_en = 1'b0;
    n_checks++; if (fifo_level !== 5'd16) $display("FAIL fp_full: got %0d expected 16", fifo_level); else n_pass++;
    repeat (FRAME_CYC - 16) tick(); // up to edge k+FRAME_CYC, last stop-bit cycle
    n_checks++; if (fifo_level !== 5'd16) $display("FAIL fp_full_before_pop: got %0d expected 16", fifo_level); else n_pass++;
    data_out = 8'hAA; data_out_en = 1'b1;
    tick();                       // pop and push on the same edge
    n_checks++; if (fifo_level !== 5'd16) $display("FAIL fp_level_pushpop: got %0d expected 16", fifo_level); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL fp_overflow_unchanged: got %b expected 0", overflow); else n_pass++;
    data_out = 8'h5A; overflow_clr = 1'b1;
    tick();                       // drop coincides with clear
    n_checks++; if (overflow !== 1'b1) $display("FAIL fp_set_wins: got %b expected 1", overflow); else n_pass++;
    n_checks++; if (fifo_level !== 5'd16) $display("FAIL fp_level_drop: got %0d expected 16", fifo_level); else n_pass++;
    data_out_en = 1'b0;
    tick();                       // clear alone
    n_checks++; if (overflow !== 1'b0) $display("FAIL fp_clear: got %b expected 0", overflow); else n_pass++;
    overflow_clr = 1'b0;
    drain(2000, to);
    n_checks++; if (to) $display("FAIL fp_drain: got timeout expected idle"); else n_pass++;
    n_checks++; if (busy_count() !== 18 * FRAME_CYC) $display("FAIL fp_busy_len: got %0d expected %0d", busy_count(), 18 * FRAME_CYC); else n_pass++;
    s = first_busy();
    decode_frame(s + 16 * FRAME_CYC, d, ok);
    n_checks++; if (!ok || d !== 8'h10) $display("FAIL fp_frame16: got %h framing_ok=%0d expected 10", d, ok); else n_pass++;
    decode_frame(s + 17 * FRAME_CYC, d, ok);
    n_checks++; if (!ok || d !== 8'hAA) $display("FAIL fp_frame17: got %h framing_ok=%0d expected aa", d, ok); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    bit to; int s; logic [7:0] d; bit ok;
    apply_reset();
    data_out = 8'hFF; data_out_en = 1'b1; tick();   // edge k
    data_out = 8'h01; tick();
    data_out = 8'h02; tick();
    data_out = 8'h03; tick();                       // edge k+3
    data_out_en = 1'b0;
    n_checks++; if (fifo_level !== 5'd3) $display("FAIL rm_queued: got %0d expected 3", fifo_level); else n_pass++;
    repeat (16) tick();                             // edge k+19: data bit 3 on tx
    n_checks++; if (tx !== 1'b1 || busy !== 1'b1) $display("FAIL rm_in_bit3: got tx=%b busy=%b expected tx=1 busy=1", tx, busy); else n_pass++;
    rst_n = 1'b0;
    tick();
    n_checks++; if (tx !== 1'b1) $display("FAIL rm_tx: got %b expected 1", tx); else n_pass++;
    n_checks++; if (fifo_level !== 5'd0) $display("FAIL rm_level: got %0d expected 0", fifo_level); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b expected 0", busy); else n_pass++;
    rst_n = 1'b1;
    tick();
    start_rec();
    data_out = 8'h55; data_out_en = 1'b1;
    tick();
    data_out_en = 1'b0;
    drain(300, to);
    n_checks++; if (to) $display("FAIL rm_drain: got timeout expected idle"); else n_pass++;
    n_checks++; if (busy_count() !== FRAME_CYC) $display("FAIL rm_busy_len: got %0d expected %0d", busy_count(), FRAME_CYC); else n_pass++;
    s = first_busy();
    decode_frame(s, d, ok);
    n_checks++; if (!ok || d !== 8'h55) $display("FAIL rm_data: got %h framing_ok=%0d expected 55", d, ok); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; data_out = 8'h00; data_out_en = 1'b0; overflow_clr = 1'b0;
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_full_pop_overflow();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_output_uart.md
CPU_OUTPUT_UART -- requirements
Module: cpu_output_uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH_LOG2, default 4, log2 of the FIFO depth (16 entries).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port data_out, input, 8 bits: byte from the CPU output port.
REQ-006 SHALL have port data_out_en, input, 1 bit: one-cycle strobe qualifying data_out; the CPU never stalls.
REQ-007 SHALL have port overflow_clr, input, 1 bit: clears the sticky overflow flag.
REQ-008 SHALL have port tx, output, 1 bit: UART serial line, idle high.
REQ-009 SHALL have port fifo_level, output, FIFO_DEPTH_LOG2+1 bits: current FIFO occupancy.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, set when a byte is dropped.
REQ-011 SHALL have port busy, output, 1 bit: high while a frame is being shifted out.

Function
REQ-012 SHALL push data_out into the FIFO on every edge where data_out_en=1 and the FIFO is not full.
REQ-013 SHALL drop the byte and set overflow when data_out_en=1, the FIFO is full and no pop occurs on the same edge.
REQ-014 SHALL accept the push when full if a pop occurs on the same edge; fifo_level stays unchanged.
REQ-015 SHALL use circular read/write pointers that wrap modulo 2^FIFO_DEPTH_LOG2; full = level equals depth.
REQ-016 SHALL run the serializer FSM through IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
REQ-017 SHALL pop and load a byte in IDLE whenever the FIFO is non-empty.
REQ-018 SHALL, from STOP with the FIFO non-empty, pop at the end of the stop bit and go directly to START, with no idle gap.
REQ-019 SHALL hold each bit for exactly CLKS_PER_BIT cycles using a baud counter that is reset on every state entry.
REQ-020 SHALL drive the frame as: start bit 0, data bits LSB first, stop bit 1.
REQ-021 SHALL, for a strobe sampled at edge k into an empty FIFO with the serializer idle, drive tx low from edge k+2.
REQ-022 SHALL hold busy=1 from the first start-bit cycle through the last stop-bit cycle; busy=0 in IDLE.
REQ-023 SHALL set overflow when an overflow set and overflow_clr coincide on the same edge (set wins).
REQ-024 SHALL update fifo_level on the edge after each push or pop.

Reset
REQ-025 SHALL, while rst_n=0 at an edge, set tx=1, fifo_level=0, overflow=0, busy=0, FSM=IDLE, baud and bit counters=0, and both pointers=0.
REQ-026 SHALL, on reset asserted mid-frame, abandon the frame, drive tx high from the next edge and discard the FIFO contents.
REQ-027 SHALL ignore data_out_en while rst_n=0.

Configuration
REQ-028 SHALL, when macro CPU_OUTPUT_UART_PARITY_EN is defined, insert an even-parity bit between the last data bit and the stop bit (11-bit frame).
REQ-029 SHALL, when CPU_OUTPUT_UART_PARITY_EN is undefined, omit the PARITY state and parity logic entirely (10-bit frame).

Structure
REQ-030 SHALL place the FSM state enum, frame bit-count constants and the default CLKS_PER_BIT in shared package cpu_io_pkg.
REQ-031 SHALL implement the FSM and baud counter in a sub-module uart_tx_serializer with a load/ready handshake; cpu_output_uart holds the FIFO and flags.

Verification (bench uses CLKS_PER_BIT=4, FIFO_DEPTH_LOG2=4)
REQ-032 SHALL cover: single 0x41 strobe after reset -> tx low 4 cycles, then bits 1,0,0,0,0,0,1,0 for 4 cycles each, then high 4 cycles; busy high for 40 cycles; overflow=0.
REQ-033 SHALL cover: 20 consecutive strobes 0x00..0x13 into an idle block -> 0x00..0x10 transmitted in order, 0x11..0x13 dropped, overflow=1, peak fifo_level=16.
REQ-034 SHALL cover: byte 0x07 -> parity bit 1 and a 44-cycle frame with CPU_OUTPUT_UART_PARITY_EN; a 40-cycle frame without it.
REQ-035 SHALL cover: rst_n pulsed low during data bit 3 of 0xFF with 3 bytes queued -> tx=1 next cycle, fifo_level=0, busy=0; a following 0x55 is sent cleanly.
REQ-036 SHALL cover: FIFO full and a pop coinciding with strobe 0xAA -> 0xAA accepted, level stays 16, overflow unchanged; overflow_clr coinciding with a drop -> overflow=1; overflow_clr alone -> overflow=0.
